gemm_c_writeback: RTL and testbench

//  Output stage of gemm_accelerator_top, directly downstream of the PE array. Accepts one finished

---
 rtl/gemm_pkg.sv | 18 +
 rtl/gemm_c_writeback_if.sv | 26 ++
 rtl/gemm_wb_fifo.sv | 45 ++++
 rtl/gemm_c_writeback.sv | 111 +++++++++++
 tb/tb_gemm_c_writeback.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/gemm_pkg.sv
// rtl/gemm_pkg.sv - shared types and sizes for the GeMM C writeback stage
package gemm_pkg;

    localparam int OutDataWidth  = 32;
    localparam int NumPE_M       = 4;
    localparam int NumPE_N       = 4;
    localparam int OutMemWidth   = OutDataWidth * NumPE_M * NumPE_N;
    localparam int AddrWidth     = 12;
    localparam int SizeAddrWidth = 8;
    localparam int TileWords     = 1;

    typedef enum logic [1:0] {
        WB_IDLE = 2'd0,
        WB_RUN  = 2'd1,
        WB_DONE = 2'd2
    } wb_state_e;

endpackage

// File: rtl/gemm_c_writeback_if.sv
// rtl/gemm_c_writeback_if.sv - tile stream in, SRAM C write port out
interface gemm_c_writeback_if #(
    parameter int OutMemWidth = 512,
    parameter int AddrWidth   = 12
) ();

    logic                   tile_valid;
    logic                   tile_ready;
    logic [OutMemWidth-1:0] tile_data;
    logic                   sram_c_stall;
    logic [AddrWidth-1:0]   sram_c_addr;
    logic [OutMemWidth-1:0] sram_c_wdata;
    logic                   sram_c_we;

    // master: PE array + SRAM C side; slave: the writeback stage
    modport master (
        output tile_valid, tile_data, sram_c_stall,
        input  tile_ready, sram_c_addr, sram_c_wdata, sram_c_we
    );

    modport slave (
        input  tile_valid, tile_data, sram_c_stall,
        output tile_ready, sram_c_addr, sram_c_wdata, sram_c_we
    );

endinterface

// File: rtl/gemm_wb_fifo.sv
// rtl/gemm_wb_fifo.sv - 2-entry tile FIFO between the PE array and SRAM C
module gemm_wb_fifo #(
    parameter int Width = 512
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] push_data_i,
    input  logic             pop_i,
    output logic [Width-1:0] pop_data_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [Width-1:0] r_mem [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;
    logic             w_push;
    logic             w_pop;

    assign full_o     = (r_count == 2'd2);
    assign empty_o    = (r_count == 2'd0);
    assign w_push     = push_i && !full_o;
    assign w_pop      = pop_i && !empty_o;
    assign pop_data_o = r_mem[r_rd_ptr];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) r_wr_ptr <= ~r_wr_ptr;
            if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    // Payload storage needs no reset: occupancy is tracked by r_count alone
    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr_ptr] <= push_data_i;
    end

endmodule

// File: rtl/gemm_c_writeback.sv
// rtl/gemm_c_writeback.sv - buffers finished tiles and writes them row-major into SRAM C
module gemm_c_writeback
    import gemm_pkg::*;
(
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     start_i,
    input  logic [SizeAddrWidth-1:0] M_size_i,
    input  logic [SizeAddrWidth-1:0] N_size_i,
    gemm_c_writeback_if.slave        bus,
    output logic                     busy_o,
    output logic                     done_o
);

    localparam int CntWidth = 2 * SizeAddrWidth;
    localparam logic [1:0] ST_IDLE = 2'(WB_IDLE);
    localparam logic [1:0] ST_RUN  = 2'(WB_RUN);
    localparam logic [1:0] ST_DONE = 2'(WB_DONE);

    logic [1:0]             r_state;
    logic [CntWidth-1:0]    r_total;
    logic [CntWidth-1:0]    r_acc_cnt;
    logic [CntWidth-1:0]    r_wr_cnt;
    logic [AddrWidth-1:0]   r_wr_addr;
    logic                   r_we;
    logic [AddrWidth-1:0]   r_addr;
    logic [OutMemWidth-1:0] r_wdata;

    logic [CntWidth-1:0]    w_total;
    logic                   w_run;
    logic                   w_ready;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_last;
    logic                   w_full;
    logic                   w_empty;
    logic [OutMemWidth-1:0] w_rdata;

    assign w_total = {{SizeAddrWidth{1'b0}}, M_size_i} * {{SizeAddrWidth{1'b0}}, N_size_i};
    assign w_run   = (r_state == ST_RUN);
    assign w_ready = w_run && !w_full && (r_acc_cnt < r_total);
    assign w_push  = bus.tile_valid && w_ready;
    assign w_pop   = w_run && !w_empty && !bus.sram_c_stall;
    assign w_last  = w_pop && (r_wr_cnt == r_total - 1'b1);

    gemm_wb_fifo #(.Width(OutMemWidth)) u_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (w_push),
        .push_data_i (bus.tile_data),
        .pop_i       (w_pop),
        .pop_data_o  (w_rdata),
        .full_o      (w_full),
        .empty_o     (w_empty)
    );

    // Address advances linearly: row-major tile order equals m*N_size+n
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= ST_IDLE;
            r_total   <= '0;
            r_acc_cnt <= '0;
            r_wr_cnt  <= '0;
            r_wr_addr <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_total   <= w_total;
                        r_acc_cnt <= '0;
                        r_wr_cnt  <= '0;
                        r_wr_addr <= '0;
                        r_state   <= (w_total == '0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_push) r_acc_cnt <= r_acc_cnt + 1'b1;
                    if (w_pop) begin
                        r_wr_cnt  <= r_wr_cnt + 1'b1;
                        r_wr_addr <= r_wr_addr + 1'b1;
                    end
                    if (w_last) r_state <= ST_DONE;
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_we <= w_pop;
            if (w_pop) begin
                r_addr  <= r_wr_addr;
                r_wdata <= w_rdata;
            end
        end
    end

    assign bus.tile_ready   = w_ready;
    assign bus.sram_c_we    = r_we;
    assign bus.sram_c_addr  = r_addr;
    assign bus.sram_c_wdata = r_wdata;
    assign busy_o           = w_run;
    assign done_o           = (r_state == ST_DONE);

endmodule

// File: tb/tb_gemm_c_writeback.sv
// tb/tb_gemm_c_writeback.sv - randomized self-checking bench for gemm_c_writeback
module tb_gemm_c_writeback;
    import gemm_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic [SizeAddrWidth-1:0] m_size, n_size;
    logic busy, done;

    always #5 clk = ~clk;

    gemm_c_writeback_if #(.OutMemWidth(OutMemWidth), .AddrWidth(AddrWidth)) bus ();

    gemm_c_writeback dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .start_i  (start),
        .M_size_i (m_size),
        .N_size_i (n_size),
        .bus      (bus),
        .busy_o   (busy),
        .done_o   (done)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [511:0] rnd_tile();
        logic [511:0] t;
        for (int i = 0; i < 16; i++) t[i*32 +: 32] = $urandom;
        return t;
    endfunction

    // Reference model: accepted tiles must reach SRAM C in order at addresses 0,1,2,...
    logic [511:0] exp_q[$];
    logic [511:0] golden [0:255];
    logic [511:0] cmem   [0:255];
    int  cyc = 0;
    int  acc_n, wr_n, done_n, cur_total;
    int  first_acc_cyc, first_we_cyc, last_we_cyc, max_gap, done_cyc, start_cyc;
    int  we_in_stall;
    int  viol_ready = 0;
    int  viol_we = 0;
    bit  run_phase = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.tile_ready && (!run_phase || acc_n >= cur_total)) viol_ready++;
            if (bus.tile_valid && bus.tile_ready) begin
                exp_q.push_back(bus.tile_data);
                if (acc_n < 256) golden[acc_n] = bus.tile_data;
                if (acc_n == 0) first_acc_cyc = cyc;
                acc_n++;
            end
            if (bus.sram_c_we) begin
                if (exp_q.size() == 0) viol_we++;
                else begin
                    check("wr_addr", 512'(bus.sram_c_addr), 512'(wr_n % 4096));
                    check("wr_data", bus.sram_c_wdata, exp_q.pop_front());
                end
                cmem[bus.sram_c_addr[7:0]] = bus.sram_c_wdata;
                if (wr_n == 0) first_we_cyc = cyc;
                else if (cyc - last_we_cyc > max_gap) max_gap = cyc - last_we_cyc;
                last_we_cyc = cyc;
                if (bus.sram_c_stall) we_in_stall++;
                wr_n++;
            end
            if (done) begin
                done_n++;
                done_cyc = cyc;
                run_phase = 0;
            end
        end
    end

    task automatic clear_model(input int total);
        exp_q.delete();
        acc_n = 0; wr_n = 0; done_n = 0; max_gap = 0; we_in_stall = 0;
        cur_total = total;
        for (int i = 0; i < 256; i++) begin
            golden[i] = '0;
            cmem[i]   = '0;
        end
    endtask

    // Feeds tiles until done (or until stop_wr writes if stop_wr >= 0); returns stall-window accept count
    task automatic run_gemm(input int m, input int n, input int gap, input bit stall_test,
                            input bit start_mid, input int stop_wr, output int stall_acc);
        int  t, prev_acc, stall_cnt;
        bit  need_new, stall_rec;
        clear_model(m * n);
        stall_acc = -1; stall_cnt = 0; stall_rec = 0;
        m_size = 8'(m); n_size = 8'(n);
        start = 1'b1; run_phase = 1; start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        t = 0; prev_acc = 0; need_new = 1;
        while (done_n == 0 && t < 3000 && !(stop_wr >= 0 && wr_n >= stop_wr)) begin
            if (acc_n != prev_acc) begin
                need_new = 1;
                prev_acc = acc_n;
            end
            if (need_new) begin
                bus.tile_data = rnd_tile();
                need_new = 0;
            end
            bus.tile_valid = ($urandom_range(0, 99) >= gap);
            if (stall_test && acc_n >= 1 && stall_cnt < 5) begin
                bus.sram_c_stall = 1'b1;
                stall_cnt++;
            end else begin
                bus.sram_c_stall = 1'b0;
                if (stall_test && stall_cnt == 5 && !stall_rec) begin
                    stall_acc = acc_n;
                    stall_rec = 1;
                end
            end
            if (start_mid && t == 3) begin
                m_size = 8'd1; n_size = 8'd1; start = 1'b1;
            end else start = 1'b0;
            @(posedge clk); #1;
            t++;
        end
        bus.tile_valid = 1'b0;
        bus.sram_c_stall = 1'b0;
        start = 1'b0;
        if (stop_wr < 0) begin
            check("done_seen", 512'(done_n != 0), 512'd1);
            repeat (4) @(posedge clk);
            #1;
            check("accepted", 512'(acc_n), 512'(cur_total));
            check("written", 512'(wr_n), 512'(cur_total));
            check("done_pulses", 512'(done_n), 512'd1);
            check("queue_drained", 512'(exp_q.size()), 512'd0);
            for (int k = 0; k < cur_total && k < 256; k++) check("cmem", cmem[k], golden[k]);
        end
    endtask

    initial begin
        int sacc;
        rst_n = 1'b0; start = 1'b0; m_size = '0; n_size = '0;
        bus.tile_valid = 1'b0; bus.tile_data = '0; bus.sram_c_stall = 1'b0;
        clear_model(0);
        #12;
        check("rst_we", 512'(bus.sram_c_we), 512'd0);
        check("rst_addr", 512'(bus.sram_c_addr), 512'd0);
        check("rst_wdata", bus.sram_c_wdata, 512'd0);
        check("rst_ready", 512'(bus.tile_ready), 512'd0);
        check("rst_busy", 512'(busy), 512'd0);
        check("rst_done", 512'(done), 512'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // T1: back-to-back, no stall
        run_gemm(1, 4, 0, 0, 0, -1, sacc);
        check("t1_latency", 512'(first_we_cyc - first_acc_cyc), 512'd2);
        check("t1_we_gap", 512'(max_gap), 512'd1);
        check("t1_done_after_writes", 512'(done_cyc >= last_we_cyc), 512'd1);

        // T2: stall after first accept
        run_gemm(4, 1, 0, 1, 0, -1, sacc);
        check("t2_stall_acc", 512'(sacc), 512'd2);
        check("t2_we_in_stall", 512'(we_in_stall), 512'd0);

        // T6a: tiles offered in IDLE are ignored
        bus.tile_data = rnd_tile();
        bus.tile_valid = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        bus.tile_valid = 1'b0;

        // T3: 8x8 with random gaps and a stray start mid-run
        run_gemm(8, 8, 40, 0, 1, -1, sacc);

        // T4: zero-size GeMM
        run_gemm(0, 5, 0, 0, 0, -1, sacc);
        check("t4_done_lat", 512'(done_cyc - start_cyc <= 2 && done_cyc > start_cyc), 512'd1);

        // T6b: valid held past the last tile, start pulsed in RUN
        run_gemm(2, 3, 0, 0, 1, -1, sacc);

        // T5: reset after 2 writes, then restart with a single tile
        run_gemm(2, 2, 0, 0, 0, 2, sacc);
        check("t5_reached", 512'(wr_n >= 2), 512'd1);
        bus.tile_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_we", 512'(bus.sram_c_we), 512'd0);
        check("t5_addr", 512'(bus.sram_c_addr), 512'd0);
        check("t5_wdata", bus.sram_c_wdata, 512'd0);
        check("t5_ready", 512'(bus.tile_ready), 512'd0);
        check("t5_busy", 512'(busy), 512'd0);
        bus.tile_valid = 1'b0;
        run_phase = 0;
        clear_model(0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("t5_no_late_we", 512'(wr_n), 512'd0);
        run_gemm(1, 1, 0, 0, 0, -1, sacc);

        check("ready_out_of_window", 512'(viol_ready), 512'd0);
        check("unexpected_we", 512'(viol_we), 512'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
